// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer sitting beside the EX-stage ALU.
// One shared 32-step datapath: shift-add multiply or restoring divide on
// operand magnitudes, followed by a sign-fix step and a one-cycle result strobe.
module ex_muldiv_seq #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            kill,
  output logic            busy,
  output logic            stall_req,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic            div_by_zero
);

  localparam int unsigned CW = $clog2(ITER);
  localparam int unsigned PW = 2 * XLEN;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state;
  logic [2:0]      op_q;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic [PW-1:0]   prod;
  logic [XLEN:0]   rem;
  logic            neg_main;
  logic            neg_rem;
  logic [CW-1:0]   cnt;

  logic            accept;
  logic            is_div;
  logic            a_signed;
  logic            b_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic            b_zero;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;
  logic            div_ge;
  logic [PW-1:0]   prod_fix;
  logic [XLEN-1:0] quot_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] sel_result;

  // Issue decode: operand signedness, magnitudes and divide-by-zero detect
  always_comb begin
    accept   = (state == IDLE) && start && !kill;
    is_div   = op[2];
    a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg    = a_signed && operand_a[XLEN-1];
    b_neg    = b_signed && operand_b[XLEN-1];
    a_abs    = a_neg ? XLEN'(-operand_a) : operand_a;
    b_abs    = b_neg ? XLEN'(-operand_b) : operand_b;
    b_zero   = (operand_b == '0);
  end

  // One iteration step of shift-add multiply and restoring divide
  always_comb begin
    mul_sum   = {1'b0, prod[PW-1:XLEN]} + (prod[0] ? {1'b0, mag_a} : {(XLEN+1){1'b0}});
    div_shift = {rem[XLEN-1:0], prod[XLEN-1]};
    div_diff  = div_shift - {1'b0, mag_b};
    div_ge    = (div_shift >= {1'b0, mag_b});
  end

  // Sign fix-up and result selection by the latched opcode
  always_comb begin
    prod_fix = neg_main ? PW'(-prod) : prod;
    quot_fix = neg_main ? XLEN'(-prod[XLEN-1:0]) : prod[XLEN-1:0];
    rem_fix  = neg_rem ? XLEN'(-rem[XLEN-1:0]) : rem[XLEN-1:0];
    case (op_q)
      OP_MUL:                      sel_result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: sel_result = prod_fix[PW-1:XLEN];
      OP_DIV, OP_DIVU:             sel_result = quot_fix;
      default:                     sel_result = rem_fix;
    endcase
  end

  assign busy      = (state != IDLE);
  assign stall_req = accept || (state == CALC) || (state == FIX);

  // Sequencer FSM with datapath registers and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      op_q         <= '0;
      mag_a        <= '0;
      mag_b        <= '0;
      prod         <= '0;
      rem          <= '0;
      neg_main     <= 1'b0;
      neg_rem      <= 1'b0;
      cnt          <= '0;
      result_valid <= 1'b0;
      result       <= '0;
      div_by_zero  <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q        <= op;
            mag_a       <= a_abs;
            mag_b       <= b_abs;
            prod        <= {{XLEN{1'b0}}, (is_div ? a_abs : b_abs)};
            rem         <= '0;
            neg_main    <= a_neg ^ b_neg;
            neg_rem     <= a_neg;
            cnt         <= CW'(ITER - 1);
            div_by_zero <= is_div && b_zero;
            if (is_div && b_zero) begin
              // Divide by zero shortcuts straight to the result strobe
              result       <= op[1] ? operand_a : {XLEN{1'b1}};
              result_valid <= 1'b1;
              state        <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (kill) begin
            state <= IDLE;
          end else begin
            if (op_q[2]) begin
              rem  <= div_ge ? div_diff : div_shift;
              prod <= {prod[PW-1:XLEN], prod[XLEN-2:0], div_ge};
            end else begin
              prod <= {mul_sum, prod[XLEN-1:1]};
            end
            cnt <= cnt - CW'(1);
            if (cnt == '0) begin
              state <= FIX;
            end
          end
        end
        FIX: begin
          if (kill) begin
            state <= IDLE;
          end else begin
            result       <= sel_result;
            result_valid <= 1'b1;
            state        <= DONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed bench for the iterative RV32M multiply/divide sequencer.
module tb_ex_muldiv_seq;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        kill;
  logic        busy;
  logic        stall_req;
  logic        result_valid;
  logic [31:0] result;
  logic        div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    logic        dbz;
  } vec_t;

  vec_t vecs[16];

  ex_muldiv_seq #(.XLEN(32), .ITER(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .op           (op),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .kill         (kill),
    .busy         (busy),
    .stall_req    (stall_req),
    .result_valid (result_valid),
    .result       (result),
    .div_by_zero  (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one op, then follow it to its strobe; poke>0 re-asserts start mid-run
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int poke, output int lat, output logic [31:0] res,
                        output logic st_issue, output logic st_ok);
    @(negedge clk);
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    #1 st_issue = stall_req;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1; res = '0; st_ok = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (result_valid) begin
        if (stall_req) st_ok = 1'b0;
        lat = c;
        res = result;
        break;
      end else if (!stall_req || !busy) begin
        st_ok = 1'b0;
      end
      if (poke != 0 && c == poke) begin
        op = 3'b101; operand_b = 32'd0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [31:0] res;
    logic        st_issue;
    logic        st_ok;
    logic        seen;

    vecs[0]  = '{3'b000, 32'd7,        32'd6,        32'h0000002A, 34, 1'b0};
    vecs[1]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34, 1'b0};
    vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 1'b0};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34, 1'b0};
    vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 1'b0};
    vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 1'b0};
    vecs[6]  = '{3'b101, 32'd100,      32'd7,        32'd14,       34, 1'b0};
    vecs[7]  = '{3'b111, 32'd100,      32'd7,        32'd2,        34, 1'b0};
    vecs[8]  = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34, 1'b0};
    vecs[9]  = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34, 1'b0};
    vecs[10] = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34, 1'b0};
    vecs[11] = '{3'b000, 32'hFFFFFFFF, 32'd3,        32'hFFFFFFFD, 34, 1'b0};
    vecs[12] = '{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  1'b1};
    vecs[13] = '{3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  1'b1};
    vecs[14] = '{3'b111, 32'd5,        32'd0,        32'd5,        1,  1'b1};
    vecs[15] = '{3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1,  1'b1};

    reset_n = 1'b0; start = 1'b0; kill = 1'b0; op = '0; operand_a = '0; operand_b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",   32'(busy),         32'd0);
    check("rst_stall",  32'(stall_req),    32'd0);
    check("rst_valid",  32'(result_valid), 32'd0);
    check("rst_result", result,            32'd0);
    check("rst_dbz",    32'(div_by_zero),  32'd0);
    reset_n = 1'b1;

    // Directed vectors, issued back-to-back
    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, lat, res, st_issue, st_ok);
      check($sformatf("v%0d_result", i), res, vecs[i].exp);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_stall_issue", i), 32'(st_issue), 32'd1);
      check($sformatf("v%0d_stall_window", i), 32'(st_ok), 32'd1);
      check($sformatf("v%0d_dbz", i), 32'(div_by_zero), 32'(vecs[i].dbz));
      if (i == 0) begin
        @(negedge clk);
        check("strobe_one_cycle", 32'(result_valid), 32'd0);
        check("idle_after_done", 32'(busy), 32'd0);
      end
    end

    // kill together with start in IDLE: start ignored
    @(negedge clk);
    op = 3'b000; operand_a = 32'd3; operand_b = 32'd4; start = 1'b1; kill = 1'b1;
    #1 check("kill_start_stall", 32'(stall_req), 32'd0);
    @(posedge clk);
    #1 start = 1'b0; kill = 1'b0;
    @(negedge clk);
    check("kill_start_busy", 32'(busy), 32'd0);

    // kill mid-CALC: abort with no strobe, result retained
    @(negedge clk);
    op = 3'b101; operand_a = 32'd100; operand_b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    check("kill_busy", 32'(busy), 32'd0);
    check("kill_stall", 32'(stall_req), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (result_valid) seen = 1'b1;
    end
    check("kill_no_valid", 32'(seen), 32'd0);
    check("kill_result_kept", result, 32'hFFFFFFF9);

    // start while busy is ignored (would be a 1-cycle DIVU by zero if taken)
    run_op(3'b000, 32'd7, 32'd6, 5, lat, res, st_issue, st_ok);
    check("poke_result", res, 32'h0000002A);
    check("poke_latency", 32'(lat), 32'd34);
    check("poke_dbz", 32'(div_by_zero), 32'd0);

    // Reset mid-CALC clears everything asynchronously
    @(negedge clk);
    op = 3'b000; operand_a = 32'd9; operand_b = 32'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy",   32'(busy),         32'd0);
    check("mid_rst_stall",  32'(stall_req),    32'd0);
    check("mid_rst_valid",  32'(result_valid), 32'd0);
    check("mid_rst_result", result,            32'd0);
    check("mid_rst_dbz",    32'(div_by_zero),  32'd0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 1) reset_n = 1'b1;
      if (result_valid) seen = 1'b1;
    end
    check("mid_rst_no_valid", 32'(seen), 32'd0);

    run_op(3'b101, 32'd100, 32'd7, 0, lat, res, st_issue, st_ok);
    check("post_rst_result", res, 32'd14);
    check("post_rst_latency", 32'(lat), 32'd34);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
